// File: rtl/vram_access_arbiter.sv
// vram_access_arbiter: shares one single-port VRAM between the CPU write
// path (drained from the write FIFO) and the display fetch path. Display
// reads win arbitration, but a streak counter forces one write through after
// STARVE_LIMIT consecutive display grants while writes are waiting.
module vram_access_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               fifo_items_count,
  output logic                     fifo_read_request,
  input  logic [ADDRESS_WIDTH-1:0] fifo_read_address,
  input  logic [DATA_WIDTH-1:0]    fifo_read_data,
  input  logic                     disp_request,
  input  logic [ADDRESS_WIDTH-1:0] disp_address,
  output logic [DATA_WIDTH-1:0]    disp_data,
  output logic                     disp_data_valid,
  output logic                     mem_request,
  output logic                     mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  input  logic [DATA_WIDTH-1:0]    mem_read_data,
  input  logic                     mem_done,
  output logic                     busy
);

  typedef enum logic [2:0] {IDLE, POP, LOAD, WRITE, READ} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                   state_q;
  logic [3:0]               disp_streak_q;
  logic [3:0]               disp_streak_d;
  logic                     fifo_read_request_q;
  logic                     mem_request_q;
  logic                     mem_write_enable_q;
  logic [ADDRESS_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0]    mem_write_data_q;
  logic [DATA_WIDTH-1:0]    disp_data_q;
  logic                     disp_data_valid_q;
  logic                     busy_q;
  logic                     write_pending;
  logic                     force_write;

  assign write_pending = (fifo_items_count != 3'd0);
  assign force_write   = write_pending && (disp_streak_q == LIMIT);

  // Streak value to load on a display grant: count up (saturating) only while
  // a write is actually being held off, otherwise nothing is starving.
  always_comb begin
    disp_streak_d = 4'd0;
    if (write_pending) begin
      if (disp_streak_q >= LIMIT) disp_streak_d = disp_streak_q;
      else                        disp_streak_d = disp_streak_q + 4'd1;
    end
  end

  // Arbitration FSM; every output is a register so the VRAM driver and FIFO
  // never see combinational glitches from the arbitration inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q             <= IDLE;
      disp_streak_q       <= 4'd0;
      fifo_read_request_q <= 1'b0;
      mem_request_q       <= 1'b0;
      mem_write_enable_q  <= 1'b0;
      mem_address_q       <= '0;
      mem_write_data_q    <= '0;
      disp_data_q         <= '0;
      disp_data_valid_q   <= 1'b0;
      busy_q              <= 1'b0;
    end else begin
      fifo_read_request_q <= 1'b0;
      disp_data_valid_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (force_write || (!disp_request && write_pending)) begin
            state_q             <= POP;
            fifo_read_request_q <= 1'b1;
            busy_q              <= 1'b1;
          end else if (disp_request) begin
            state_q            <= READ;
            mem_address_q      <= disp_address;
            mem_write_enable_q <= 1'b0;
            mem_request_q      <= 1'b1;
            disp_streak_q      <= disp_streak_d;
            busy_q             <= 1'b1;
          end
        end
        POP: begin
          state_q <= LOAD;
        end
        LOAD: begin
          state_q            <= WRITE;
          mem_address_q      <= fifo_read_address;
          mem_write_data_q   <= fifo_read_data;
          mem_write_enable_q <= 1'b1;
          mem_request_q      <= 1'b1;
          disp_streak_q      <= 4'd0;
        end
        WRITE: begin
          if (mem_done) begin
            state_q            <= IDLE;
            mem_request_q      <= 1'b0;
            mem_write_enable_q <= 1'b0;
            busy_q             <= 1'b0;
          end
        end
        READ: begin
          if (mem_done) begin
            state_q           <= IDLE;
            disp_data_q       <= mem_read_data;
            disp_data_valid_q <= 1'b1;
            mem_request_q     <= 1'b0;
            busy_q            <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          mem_request_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_read_request = fifo_read_request_q;
  assign mem_request       = mem_request_q;
  assign mem_write_enable  = mem_write_enable_q;
  assign mem_address       = mem_address_q;
  assign mem_write_data    = mem_write_data_q;
  assign disp_data         = disp_data_q;
  assign disp_data_valid   = disp_data_valid_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// tb_vram_access_arbiter: directed bench for vram_access_arbiter. Inputs are
// driven and outputs sampled on the falling clock edge; the bench plays the
// role of the write FIFO, display controller and VRAM driver.
module tb_vram_access_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  fifo_items_count;
  logic        fifo_read_request;
  logic [15:0] fifo_read_address;
  logic [15:0] fifo_read_data;
  logic        disp_request;
  logic [15:0] disp_address;
  logic [15:0] disp_data;
  logic        disp_data_valid;
  logic        mem_request;
  logic        mem_write_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic        mem_done;
  logic        busy;

  int checks;
  int passed;
  int popCount;

  vram_access_arbiter #(
    .DATA_WIDTH(16),
    .ADDRESS_WIDTH(16),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fifo_items_count(fifo_items_count),
    .fifo_read_request(fifo_read_request),
    .fifo_read_address(fifo_read_address),
    .fifo_read_data(fifo_read_data),
    .disp_request(disp_request),
    .disp_address(disp_address),
    .disp_data(disp_data),
    .disp_data_valid(disp_data_valid),
    .mem_request(mem_request),
    .mem_write_enable(mem_write_enable),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .mem_done(mem_done),
    .busy(busy)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts pop strobes; each legal strobe is one cycle wide so it is seen on
  // exactly one falling edge.
  initial popCount = 0;
  always @(negedge clk) if (fifo_read_request) popCount++;

  // Hard stop in case a sequence wedges despite the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] count, input logic [15:0] faddr,
                               input logic [15:0] fdata, input logic dreq,
                               input logic [15:0] daddr, input logic [15:0] rdata);
    fifo_items_count  = count;
    fifo_read_address = faddr;
    fifo_read_data    = fdata;
    disp_request      = dreq;
    disp_address      = daddr;
    mem_read_data     = rdata;
  endtask

  // Waits (bounded) for the next falling edge with mem_request high.
  task automatic waitReq(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!mem_request && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_req"}, 32'(mem_request), 32'd1);
  endtask

  initial begin
    checks   = 0;
    passed   = 0;
    reset    = 1'b1;
    mem_done = 1'b0;
    applyStimulus(3'd0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);

    // Reset state: every output low.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_req",   32'(mem_request), 32'd0);
    checkOutput("rst_we",    32'(mem_write_enable), 32'd0);
    checkOutput("rst_addr",  32'(mem_address), 32'd0);
    checkOutput("rst_wdata", 32'(mem_write_data), 32'd0);
    checkOutput("rst_ddata", 32'(disp_data), 32'd0);
    checkOutput("rst_dval",  32'(disp_data_valid), 32'd0);
    checkOutput("rst_pop",   32'(fifo_read_request), 32'd0);
    checkOutput("rst_busy",  32'(busy), 32'd0);

    // Single FIFO write, memory answers two cycles after the request rises.
    reset = 1'b0;
    applyStimulus(3'd1, 16'h1234, 16'hBEEF, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("w1_pop",  32'(fifo_read_request), 32'd1);
    checkOutput("w1_busy", 32'(busy), 32'd1);
    fifo_items_count = 3'd0;
    @(negedge clk);
    checkOutput("w1_pop_once", 32'(fifo_read_request), 32'd0);
    checkOutput("w1_load_req", 32'(mem_request), 32'd0);
    @(negedge clk);
    checkOutput("w1_req",   32'(mem_request), 32'd1);
    checkOutput("w1_we",    32'(mem_write_enable), 32'd1);
    checkOutput("w1_addr",  32'(mem_address), 32'h1234);
    checkOutput("w1_wdata", 32'(mem_write_data), 32'hBEEF);
    @(negedge clk);
    checkOutput("w1_hold", 32'(mem_request), 32'd1);
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    checkOutput("w1_done_req",  32'(mem_request), 32'd0);
    checkOutput("w1_done_we",   32'(mem_write_enable), 32'd0);
    checkOutput("w1_done_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("w1_pops", 32'(popCount), 32'd1);
    checkOutput("w1_idle", 32'(busy), 32'd0);

    // Display-only read.
    applyStimulus(3'd0, 16'h0, 16'h0, 1'b1, 16'h00A0, 16'h5A5A);
    @(negedge clk);
    checkOutput("r1_req",  32'(mem_request), 32'd1);
    checkOutput("r1_we",   32'(mem_write_enable), 32'd0);
    checkOutput("r1_addr", 32'(mem_address), 32'h00A0);
    checkOutput("r1_busy", 32'(busy), 32'd1);
    checkOutput("r1_nval", 32'(disp_data_valid), 32'd0);
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    disp_request = 1'b0;
    checkOutput("r1_val",   32'(disp_data_valid), 32'd1);
    checkOutput("r1_data",  32'(disp_data), 32'h5A5A);
    checkOutput("r1_dreq",  32'(mem_request), 32'd0);
    @(negedge clk);
    checkOutput("r1_pulse", 32'(disp_data_valid), 32'd0);

    // From a fresh reset, display and FIFO request together: read first.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(3'd1, 16'h2222, 16'h3333, 1'b1, 16'h0BB0, 16'h1111);
    @(negedge clk);
    checkOutput("s_req",  32'(mem_request), 32'd1);
    checkOutput("s_we",   32'(mem_write_enable), 32'd0);
    checkOutput("s_addr", 32'(mem_address), 32'h0BB0);
    checkOutput("s_npop", 32'(fifo_read_request), 32'd0);
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    checkOutput("s_val",  32'(disp_data_valid), 32'd1);
    checkOutput("s_data", 32'(disp_data), 32'h1111);
    disp_request = 1'b0;
    @(negedge clk);
    checkOutput("s_pop", 32'(fifo_read_request), 32'd1);
    fifo_items_count = 3'd0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("s_wreq",  32'(mem_request), 32'd1);
    checkOutput("s_wwe",   32'(mem_write_enable), 32'd1);
    checkOutput("s_waddr", 32'(mem_address), 32'h2222);
    checkOutput("s_wdata", 32'(mem_write_data), 32'h3333);
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    checkOutput("s_wdone", 32'(mem_request), 32'd0);
    checkOutput("s_wbusy", 32'(busy), 32'd0);

    // Done in the first cycle of the request; next op after one idle cycle.
    applyStimulus(3'd0, 16'h0, 16'h0, 1'b1, 16'h0C0C, 16'hCAFE);
    @(negedge clk);
    checkOutput("l1_req", 32'(mem_request), 32'd1);
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    checkOutput("l1_idle_req",  32'(mem_request), 32'd0);
    checkOutput("l1_idle_busy", 32'(busy), 32'd0);
    checkOutput("l1_val",       32'(disp_data_valid), 32'd1);
    checkOutput("l1_data",      32'(disp_data), 32'hCAFE);
    @(negedge clk);
    checkOutput("l1_next_req",  32'(mem_request), 32'd1);
    checkOutput("l1_next_busy", 32'(busy), 32'd1);
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    disp_request = 1'b0;
    checkOutput("l1_val2", 32'(disp_data_valid), 32'd1);

    // Display held with three writes waiting: R R R R W R R R R W.
    popCount = 0;
    applyStimulus(3'd3, 16'h4444, 16'h5555, 1'b1, 16'h0D00, 16'h6666);
    for (int i = 0; i < 10; i++) begin
      waitReq($sformatf("st%0d", i));
      checkOutput($sformatf("st%0d_we", i), 32'(mem_write_enable),
                  32'((i == 4) || (i == 9)));
      mem_done = 1'b1;
      @(negedge clk);
      mem_done = 1'b0;
    end
    applyStimulus(3'd0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    checkOutput("st_pops", 32'(popCount), 32'd2);

    // Reset in the middle of a write with done still outstanding.
    applyStimulus(3'd1, 16'h7777, 16'h8888, 1'b0, 16'h0, 16'h0);
    waitReq("ab");
    checkOutput("ab_we", 32'(mem_write_enable), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("ab_req",  32'(mem_request), 32'd0);
    checkOutput("ab_busy", 32'(busy), 32'd0);
    checkOutput("ab_we0",  32'(mem_write_enable), 32'd0);
    @(negedge clk);
    fifo_items_count = 3'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    checkOutput("ab_late_busy", 32'(busy), 32'd0);
    checkOutput("ab_late_req",  32'(mem_request), 32'd0);
    checkOutput("ab_late_val",  32'(disp_data_valid), 32'd0);
    @(negedge clk);
    checkOutput("ab_still_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
